// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin arbiter launching two requesters' transactions on one I2C master, with a watchdog.
// Optional I2C_ARB_RETRY_EN: a NACKed transaction is relaunched once before Err is reported.
module i2c_txn_arbiter #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] Req,
    input  logic [1:0] Rw_in,
    input  logic [7:0] Ptr_in0,
    input  logic [7:0] Ptr_in1,
    input  logic [1:0] Setp_in,
    input  logic       Ready,
    input  logic       Error,
    output logic       Start,
    output logic       R_W,
    output logic [7:0] Pointer,
    output logic       Set_pointer,
    output logic [1:0] Gnt,
    output logic [1:0] Done,
    output logic [1:0] Err,
    output logic       Timeout
);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP} state_t;
    localparam logic [15:0] TO = 16'(TIMEOUT_CYC);

    state_t      state_q, state_d;
    logic        start_q, start_d, rw_q, rw_d, setp_q, setp_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [1:0]  gnt_q, gnt_d, done_q, done_d, err_q, err_d;
    logic        timeout_q, timeout_d, eflag_q, eflag_d, last_q, last_d;
    logic [15:0] wd_q, wd_d;
    logic        pick, eflag_n, wd_hit, retry_ok;
`ifdef I2C_ARB_RETRY_EN
    logic        retry_q, retry_d;
    assign retry_ok = !retry_q;
`else
    assign retry_ok = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        rw_d      = rw_q;
        ptr_d     = ptr_q;
        setp_d    = setp_q;
        gnt_d     = gnt_q;
        done_d    = 2'b00;
        err_d     = 2'b00;
        timeout_d = 1'b0;
        wd_d      = wd_q;
        eflag_d   = eflag_q;
        last_d    = last_q;
`ifdef I2C_ARB_RETRY_EN
        retry_d   = retry_q;
`endif
        // On a tie the requester not served last wins; otherwise the sole requester.
        pick      = (Req == 2'b11) ? ~last_q : Req[1];
        eflag_n   = eflag_q | Error;
        wd_hit    = (wd_q + 16'd1) == TO;
        case (state_q)
            IDLE: begin
                if (Ready && Req != 2'b00) begin
                    rw_d    = Rw_in[pick];
                    ptr_d   = pick ? Ptr_in1 : Ptr_in0;
                    setp_d  = Setp_in[pick];
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    eflag_d = 1'b0;
`ifdef I2C_ARB_RETRY_EN
                    retry_d = 1'b0;
`endif
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                start_d = 1'b1;
                wd_d    = 16'd0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY, WAIT_DONE: begin
                wd_d    = wd_q + 16'd1;
                eflag_d = eflag_n;
                if (wd_hit) begin
                    timeout_d = 1'b1;
                    err_d     = gnt_q;
                    gnt_d     = 2'b00;
                    last_d    = gnt_q[1];
                    state_d   = IDLE;
                end else if (state_q == WAIT_BUSY) begin
                    state_d = Ready ? WAIT_BUSY : WAIT_DONE;
                end else if (Ready) begin
                    // Response pulses are registered on entry so they are visible during RESP.
                    done_d  = eflag_n ? 2'b00 : gnt_q;
                    err_d   = (eflag_n && !retry_ok) ? gnt_q : 2'b00;
                    state_d = RESP;
                end
            end
            RESP: begin
`ifdef I2C_ARB_RETRY_EN
                if (eflag_q && !retry_q) begin
                    retry_d = 1'b1;
                    eflag_d = 1'b0;
                    state_d = LAUNCH;
                end else
`endif
                begin
                    gnt_d   = 2'b00;
                    last_d  = gnt_q[1];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            rw_q      <= 1'b0;
            ptr_q     <= 8'h00;
            setp_q    <= 1'b0;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            err_q     <= 2'b00;
            timeout_q <= 1'b0;
            wd_q      <= 16'd0;
            eflag_q   <= 1'b0;
            last_q    <= 1'b1;
`ifdef I2C_ARB_RETRY_EN
            retry_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            rw_q      <= rw_d;
            ptr_q     <= ptr_d;
            setp_q    <= setp_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            wd_q      <= wd_d;
            eflag_q   <= eflag_d;
            last_q    <= last_d;
`ifdef I2C_ARB_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    assign Start       = start_q;
    assign R_W         = rw_q;
    assign Pointer     = ptr_q;
    assign Set_pointer = setp_q;
    assign Gnt         = gnt_q;
    assign Done        = done_q;
    assign Err         = err_q;
    assign Timeout     = timeout_q;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: directed bench for i2c_txn_arbiter; a second instance runs with a 16-cycle watchdog.
module tb_i2c_txn_arbiter;
    logic       Clk, Rst, Ready, Error;
    logic [1:0] Req, Rw_in, Setp_in;
    logic [7:0] Ptr_in0, Ptr_in1;
    logic       Start, R_W, Set_pointer, Timeout;
    logic [7:0] Pointer;
    logic [1:0] Gnt, Done, Err;
    logic       t_start, t_rw, t_setp, t_timeout;
    logic [7:0] t_ptr;
    logic [1:0] t_gnt, t_done, t_err;
    int checks = 0;
    int errors = 0;

    i2c_txn_arbiter dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Rw_in(Rw_in), .Ptr_in0(Ptr_in0), .Ptr_in1(Ptr_in1),
        .Setp_in(Setp_in), .Ready(Ready), .Error(Error), .Start(Start), .R_W(R_W),
        .Pointer(Pointer), .Set_pointer(Set_pointer), .Gnt(Gnt), .Done(Done), .Err(Err),
        .Timeout(Timeout)
    );

    i2c_txn_arbiter #(.TIMEOUT_CYC(16)) dut_to (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Rw_in(Rw_in), .Ptr_in0(Ptr_in0), .Ptr_in1(Ptr_in1),
        .Setp_in(Setp_in), .Ready(Ready), .Error(Error), .Start(t_start), .R_W(t_rw),
        .Pointer(t_ptr), .Set_pointer(t_setp), .Gnt(t_gnt), .Done(t_done), .Err(t_err),
        .Timeout(t_timeout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (!Rst) begin
            checks++;
            if (Gnt == 2'b11 || (Done & Err) != 2'b00) begin
                errors++;
                $display("FAIL onehot: Gnt=%b Done=%b Err=%b", Gnt, Done, Err);
            end
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1; Req = 2'b00; Error = 1'b0; Ready = 1'b1;
        cyc(); cyc();
        Rst = 1'b0;
    endtask

    task automatic master_txn(input int busy, output int starts);
        cyc();
        starts = int'(Start);
        Ready = 1'b0;
        cyc();
        starts += int'(Start);
        repeat (busy) begin cyc(); starts += int'(Start); end
        Ready = 1'b1;
        cyc();
        starts += int'(Start);
    endtask

    task automatic test_reset();
        Rst = 1'b1; Req = 2'b00; Rw_in = 2'b00; Setp_in = 2'b00; Ptr_in0 = 8'h00; Ptr_in1 = 8'h00;
        Ready = 1'b1; Error = 1'b0;
        cyc(); cyc();
        checks++;
        if ({Start, R_W, Pointer, Set_pointer, Gnt, Done, Err, Timeout} !== 17'd0) begin
            errors++;
            $display("FAIL reset_dut: got %h expected 0", {Start, R_W, Pointer, Set_pointer, Gnt, Done, Err, Timeout});
        end
        checks++;
        if ({t_start, t_rw, t_ptr, t_setp, t_gnt, t_done, t_err, t_timeout} !== 17'd0) begin
            errors++;
            $display("FAIL reset_dut_to: got %h expected 0", {t_start, t_rw, t_ptr, t_setp, t_gnt, t_done, t_err, t_timeout});
        end
        Rst = 1'b0;
    endtask

    task automatic test_single();
        int n;
        int resp;
        do_reset();
        Req = 2'b01; Rw_in = 2'b01; Ptr_in0 = 8'h02; Ptr_in1 = 8'hFF; Setp_in = 2'b00;
        cyc();
        checks++;
        if ({Gnt, Start} !== {2'b01, 1'b0}) begin
            errors++;
            $display("FAIL single_grant: Gnt,Start=%b expected 010", {Gnt, Start});
        end
        cyc();
        n = int'(Start);
        checks++;
        if ({Start, R_W, Pointer, Set_pointer} !== {1'b1, 1'b1, 8'h02, 1'b0}) begin
            errors++;
            $display("FAIL single_launch: got %h expected %h", {Start, R_W, Pointer, Set_pointer}, {1'b1, 1'b1, 8'h02, 1'b0});
        end
        repeat (2) begin cyc(); n += int'(Start); end
        Ready = 1'b0;
        resp = 0;
        repeat (40) begin cyc(); n += int'(Start); resp += int'(|{Done, Err}); end
        checks++;
        if (resp != 0) begin
            errors++;
            $display("FAIL single_early_resp: got %0d pulses expected 0", resp);
        end
        Ready = 1'b1;
        cyc();
        checks++;
        if ({Done, Err, R_W, Pointer} !== {2'b01, 2'b00, 1'b1, 8'h02}) begin
            errors++;
            $display("FAIL single_done: Done=%b Err=%b R_W=%b Pointer=%h expected 01 00 1 02", Done, Err, R_W, Pointer);
        end
        Req = 2'b00;
        cyc();
        checks++;
        if ({Done, Gnt} !== 4'b0000) begin
            errors++;
            $display("FAIL single_release: Done=%b Gnt=%b expected 00 00", Done, Gnt);
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL single_start_count: got %0d expected 1", n);
        end
    endtask

    task automatic test_round_robin();
        int s;
        do_reset();
        Req = 2'b11; Rw_in = 2'b10; Ptr_in0 = 8'hAA; Ptr_in1 = 8'h55; Setp_in = 2'b10;
        cyc();
        checks++;
        if ({Gnt, R_W, Pointer, Set_pointer} !== {2'b01, 1'b0, 8'hAA, 1'b0}) begin
            errors++;
            $display("FAIL rr_grant1: got %h expected %h", {Gnt, R_W, Pointer, Set_pointer}, {2'b01, 1'b0, 8'hAA, 1'b0});
        end
        master_txn(2, s);
        checks++;
        if ({Done, s} !== {2'b01, 32'd1}) begin
            errors++;
            $display("FAIL rr_done1: Done=%b starts=%0d expected 01 1", Done, s);
        end
        cyc();
        checks++;
        if (Gnt !== 2'b00) begin
            errors++;
            $display("FAIL rr_gap: Gnt=%b expected 00", Gnt);
        end
        cyc();
        checks++;
        if ({Gnt, R_W, Pointer, Set_pointer} !== {2'b10, 1'b1, 8'h55, 1'b1}) begin
            errors++;
            $display("FAIL rr_grant2: got %h expected %h", {Gnt, R_W, Pointer, Set_pointer}, {2'b10, 1'b1, 8'h55, 1'b1});
        end
        master_txn(0, s);
        checks++;
        if (Done !== 2'b10) begin
            errors++;
            $display("FAIL rr_done2: Done=%b expected 10", Done);
        end
        cyc(); cyc();
        checks++;
        if (Gnt !== 2'b01) begin
            errors++;
            $display("FAIL rr_grant3: Gnt=%b expected 01", Gnt);
        end
        master_txn(1, s);
        checks++;
        if (Done !== 2'b01) begin
            errors++;
            $display("FAIL rr_done3: Done=%b expected 01", Done);
        end
        Req = 2'b00;
        cyc();
    endtask

    task automatic test_nack();
        do_reset();
        Req = 2'b01; Rw_in = 2'b00; Ptr_in0 = 8'h10;
        cyc();
        Req = 2'b00;
        cyc();
        Ready = 1'b0;
        cyc();
        Error = 1'b1;
        cyc();
        Error = 1'b0;
        cyc();
        Ready = 1'b1;
        cyc();
`ifdef I2C_ARB_RETRY_EN
        checks++;
        if ({Done, Err, Gnt} !== {2'b00, 2'b00, 2'b01}) begin
            errors++;
            $display("FAIL nack_retry_resp: Done=%b Err=%b Gnt=%b expected 00 00 01", Done, Err, Gnt);
        end
        cyc(); cyc();
        checks++;
        if (Start !== 1'b1) begin
            errors++;
            $display("FAIL nack_retry_start: Start=%b expected 1", Start);
        end
        Ready = 1'b0;
        cyc(); cyc();
        Ready = 1'b1;
        cyc();
        checks++;
        if ({Done, Err} !== {2'b01, 2'b00}) begin
            errors++;
            $display("FAIL nack_retry_done: Done=%b Err=%b expected 01 00", Done, Err);
        end
`else
        checks++;
        if ({Done, Err} !== {2'b00, 2'b01}) begin
            errors++;
            $display("FAIL nack_err: Done=%b Err=%b expected 00 01", Done, Err);
        end
`endif
        cyc();
        checks++;
        if ({Done, Err, Gnt} !== 6'b0) begin
            errors++;
            $display("FAIL nack_release: Done=%b Err=%b Gnt=%b expected 00 00 00", Done, Err, Gnt);
        end
    endtask

    task automatic test_timeout();
        int early;
        do_reset();
        Req = 2'b01;
        cyc();
        cyc();
        checks++;
        if (t_start !== 1'b1) begin
            errors++;
            $display("FAIL to_start: Start=%b expected 1", t_start);
        end
        Ready = 1'b0;
        early = 0;
        repeat (15) begin cyc(); early += int'(t_timeout) + int'(|t_err); end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL to_early: got %0d pulses expected 0", early);
        end
        cyc();
        checks++;
        if ({t_timeout, t_err, t_done, t_gnt} !== {1'b1, 2'b01, 2'b00, 2'b00}) begin
            errors++;
            $display("FAIL to_fire: Timeout=%b Err=%b Done=%b Gnt=%b expected 1 01 00 00", t_timeout, t_err, t_done, t_gnt);
        end
        cyc();
        checks++;
        if ({t_timeout, t_err, t_gnt} !== 5'b0) begin
            errors++;
            $display("FAIL to_after: Timeout=%b Err=%b Gnt=%b expected 0 00 00", t_timeout, t_err, t_gnt);
        end
        Req = 2'b00;
        Ready = 1'b1;
        cyc(); cyc(); cyc();
        checks++;
        if ({t_start, t_gnt} !== 3'b0) begin
            errors++;
            $display("FAIL to_no_retry: Start=%b Gnt=%b expected 0 00", t_start, t_gnt);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        do_reset();
        Req = 2'b01; Rw_in = 2'b01; Ptr_in0 = 8'h5A; Setp_in = 2'b01;
        cyc(); cyc();
        Ready = 1'b0;
        cyc(); cyc();
        Rst = 1'b1;
        cyc();
        checks++;
        if ({Start, R_W, Pointer, Set_pointer, Gnt, Done, Err, Timeout} !== 17'd0) begin
            errors++;
            $display("FAIL reset_mid: got %h expected 0", {Start, R_W, Pointer, Set_pointer, Gnt, Done, Err, Timeout});
        end
        Rst = 1'b0; Req = 2'b00; Ready = 1'b1;
        pulses = 0;
        repeat (3) begin cyc(); pulses += int'(|{Done, Err}); end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_mid_resp: got %0d pulses expected 0", pulses);
        end
    endtask

    task automatic test_ready_block();
        int granted;
        do_reset();
        Ready = 1'b0; Req = 2'b10;
        granted = 0;
        repeat (3) begin cyc(); granted += int'(|Gnt); end
        checks++;
        if (granted != 0) begin
            errors++;
            $display("FAIL ready_block: got %0d grant cycles expected 0", granted);
        end
        Ready = 1'b1;
        cyc();
        checks++;
        if (Gnt !== 2'b10) begin
            errors++;
            $display("FAIL ready_grant: Gnt=%b expected 10", Gnt);
        end
        Req = 2'b00;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_nack();
        test_timeout();
        test_reset_mid();
        test_ready_block();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
